bram_access_arbiter: RTL

//  Shares the single-port user BRAM between the Wishbone slave port (management SoC) and a

---
 rtl/bram_access_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/bram_access_arbiter.sv
// rtl/bram_access_arbiter.sv - round-robin sharing of one user BRAM between a Wishbone slave and an accelerator port
module bram_access_arbiter #(
    parameter logic [11:0] ADDR_BASE = 12'h380,
    parameter int          DELAYS    = 10
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        acc_req_i,
    input  logic        acc_we_i,
    input  logic [3:0]  acc_wstrb_i,
    input  logic [19:0] acc_adr_i,
    input  logic [31:0] acc_wdata_i,
    output logic        acc_gnt_o,
    output logic        acc_rvalid_o,
    output logic [31:0] acc_rdata_o,
    output logic        bram_en_o,
    output logic [3:0]  bram_we_o,
    output logic [31:0] bram_adr_o,
    output logic [31:0] bram_di_o,
    input  logic [31:0] bram_do_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic [7:0] LAST_CNT = DELAYS[7:0];

    state_t      state_q, state_d;
    logic        owner_acc_q, owner_acc_d;
    logic        we_q, we_d;
    logic [3:0]  strb_q, strb_d;
    logic [19:0] off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        prio_acc_q, prio_acc_d;
    logic        wb_req;
    logic        grant_acc;

    assign wb_req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:20] == ADDR_BASE);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= S_IDLE;
            owner_acc_q <= 1'b0;
            we_q        <= 1'b0;
            strb_q      <= 4'h0;
            off_q       <= 20'h0;
            wdata_q     <= 32'h0;
            cnt_q       <= 8'h0;
            rdata_q     <= 32'h0;
            prio_acc_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_acc_q <= owner_acc_d;
            we_q        <= we_d;
            strb_q      <= strb_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            prio_acc_q  <= prio_acc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_acc_d  = owner_acc_q;
        we_d         = we_q;
        strb_d       = strb_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        prio_acc_d   = prio_acc_q;
        grant_acc    = 1'b0;
        wbs_ack_o    = 1'b0;
        wbs_dat_o    = 32'h0;
        acc_gnt_o    = 1'b0;
        acc_rvalid_o = 1'b0;
        acc_rdata_o  = 32'h0;
        bram_en_o    = 1'b0;
        bram_we_o    = 4'h0;
        bram_adr_o   = 32'h0;
        bram_di_o    = 32'h0;
        busy_o       = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (wb_req || acc_req_i) begin
                    grant_acc   = acc_req_i && (!wb_req || prio_acc_q);
                    owner_acc_d = grant_acc;
                    cnt_d       = 8'h0;
                    state_d     = S_ACCESS;
                    if (grant_acc) begin
                        we_d      = acc_we_i;
                        strb_d    = acc_wstrb_i & {4{acc_we_i}};
                        off_d     = acc_adr_i;
                        wdata_d   = acc_wdata_i;
                        // gated so the combinational grant stays low while reset is held
                        acc_gnt_o = wb_rst_n;
                    end else begin
                        we_d    = wbs_we_i;
                        strb_d  = wbs_sel_i & {4{wbs_we_i}};
                        off_d   = wbs_adr_i[19:0];
                        wdata_d = wbs_dat_i;
                    end
                end
            end
            S_ACCESS: begin
                bram_en_o  = 1'b1;
                bram_adr_o = {ADDR_BASE, off_q};
                bram_di_o  = wdata_q;
                if (cnt_q == 8'h0) begin
                    bram_we_o = strb_q;
                end
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == LAST_CNT) begin
                    rdata_d = bram_do_i;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (owner_acc_q) begin
                    acc_rvalid_o = 1'b1;
                    acc_rdata_o  = we_q ? 32'h0 : rdata_q;
                end else if (wbs_cyc_i && wbs_stb_i) begin
                    wbs_ack_o = 1'b1;
                    wbs_dat_o = we_q ? 32'h0 : rdata_q;
                end
                prio_acc_d = !owner_acc_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
